// File: rtl/dcache_pkg.sv
// Shared types and widths for the L1 data cache controller and its storage.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int BLOCK_BITS      = 128;
  localparam int WORD_BITS       = 32;
  localparam int OFFSET_BITS     = 4;
  localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;
  localparam int WSEL_BITS       = 2;

  // Tag width left over after the set index and the byte offset.
  function automatic int calc_tag_bits(input int addr_bits, input int index_bits);
    return addr_bits - index_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache.
// Combinational read of the indexed set; registered writes in either
// word-write mode (store hit) or line-fill mode (refill from memory).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] index,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [BLOCK_BITS-1:0] rd_line,
  input  logic                  word_we,
  input  logic [WSEL_BITS-1:0]  word_sel,
  input  logic [WORD_BITS-1:0]  word_data,
  input  logic                  fill_we,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [BLOCK_BITS-1:0] fill_line
);

  localparam int NUM_SETS = 2 ** INDEX_BITS;

  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;
  logic [TAG_BITS-1:0] tag_mem [NUM_SETS];

  // Line state: reset invalidates everything, a fill leaves the line clean,
  // a store hit marks it dirty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fill_we) begin
      valid_reg[index] <= 1'b1;
      dirty_reg[index] <= 1'b0;
    end else if (word_we) begin
      dirty_reg[index] <= 1'b1;
    end
  end

  // Tag is only written on a fill; it is not cleared by reset.
  always_ff @(posedge clock) begin
    if (reset && fill_we) begin
      tag_mem[index] <= fill_tag;
    end
  end

  // One storage column per word so a store touches only its own word.
  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
      logic [WORD_BITS-1:0] word_mem [NUM_SETS];
      logic                 word_sel_hit;

      assign word_sel_hit = word_we && (word_sel == WSEL_BITS'(gi));

      // Fill writes every column; a store writes only the selected one.
      always_ff @(posedge clock) begin
        if (reset) begin
          if (fill_we) begin
            word_mem[index] <= fill_line[gi*WORD_BITS +: WORD_BITS];
          end else if (word_sel_hit) begin
            word_mem[index] <= word_data;
          end
        end
      end

      assign rd_line[gi*WORD_BITS +: WORD_BITS] = word_mem[index];
    end
  endgenerate

  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_reg[index];
  assign rd_dirty = dirty_reg[index];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete combinationally in IDLE; misses optionally write back the
// dirty victim, then refill the line and re-compare in IDLE.
module l1_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS  = 20,
  parameter int INDEX_BITS = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_ren,
  input  logic                   cpu_wen,
  input  logic [ADDR_BITS-1:0]   cpu_addr,
  input  logic [WORD_BITS-1:0]   cpu_wdata,
  output logic [WORD_BITS-1:0]   cpu_rdata,
  output logic                   cpu_stall,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [ADDR_BITS-5:0]   mem_block_address,
  output logic [BLOCK_BITS-1:0]  mem_din,
  input  logic                   mem_ready,
  input  logic                   mem_done,
  input  logic [BLOCK_BITS-1:0]  mem_dout
);

  localparam int TAG_BITS = calc_tag_bits(ADDR_BITS, INDEX_BITS);

  state_t state_reg, state_next;
  logic   mem_ren_reg, mem_ren_next;
  logic   mem_wen_reg, mem_wen_next;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [WSEL_BITS-1:0]  word_sel;
  logic                  addr_lsb_unused;

  logic [TAG_BITS-1:0]   rd_tag;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [BLOCK_BITS-1:0] rd_line;
  logic [WORD_BITS-1:0]  line_words [WORDS_PER_BLOCK];

  logic req;
  logic hit;
  logic idle_hit;
  logic word_we;
  logic fill_we;

  assign index           = cpu_addr[INDEX_BITS+3:4];
  assign tag             = cpu_addr[ADDR_BITS-1:INDEX_BITS+4];
  assign word_sel        = cpu_addr[3:2];
  assign addr_lsb_unused = ^cpu_addr[1:0];

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .index     (index),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_line   (rd_line),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (cpu_wdata),
    .fill_we   (fill_we),
    .fill_tag  (tag),
    .fill_line (mem_dout)
  );

  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_split
      assign line_words[gi] = rd_line[gi*WORD_BITS +: WORD_BITS];
    end
  endgenerate

  assign req       = cpu_ren | cpu_wen;
  assign hit       = rd_valid && (rd_tag == tag);
  assign idle_hit  = (state_reg == IDLE) && hit;
  assign cpu_stall = req && !idle_hit;
  assign cpu_rdata = line_words[word_sel];

  // Stores complete only as hits in IDLE; a store miss retires after refill.
  assign word_we = cpu_wen && idle_hit;
  assign fill_we = (state_reg == ALLOCATE) && mem_ren_reg && mem_done;

  // Write-back targets the victim's own address; refill targets the request.
  assign mem_block_address = (state_reg == WRITEBACK) ? {rd_tag, index}
                                                      : cpu_addr[ADDR_BITS-1:4];
  assign mem_din = rd_line;
  assign mem_ren = mem_ren_reg;
  assign mem_wen = mem_wen_reg;

  // State and memory-request registers; reset aborts any transfer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      mem_ren_reg <= 1'b0;
      mem_wen_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mem_ren_reg <= mem_ren_next;
      mem_wen_reg <= mem_wen_next;
    end
  end

  // Next state and request handshake: raise when Dmem is ready, hold to done.
  always_comb begin
    state_next   = state_reg;
    mem_ren_next = mem_ren_reg;
    mem_wen_next = mem_wen_reg;
    case (state_reg)
      IDLE: begin
        if (req && !hit) begin
          state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_wen_reg) begin
          if (mem_done) begin
            mem_wen_next = 1'b0;
            state_next   = ALLOCATE;
          end
        end else if (mem_ready) begin
          mem_wen_next = 1'b1;
        end
      end
      ALLOCATE: begin
        if (mem_ren_reg) begin
          if (mem_done) begin
            mem_ren_next = 1'b0;
            state_next   = IDLE;
          end
        end else if (mem_ready) begin
          mem_ren_next = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_ren_next = 1'b0;
        mem_wen_next = 1'b0;
      end
    endcase
  end

endmodule
